// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two ALU requesters, the shared ALU and the arbiter.
// The arbiter takes the slave view; the requester/ALU environment takes the master view.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
);
   logic             req0_vld;
   logic             req0_rdy;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             req1_vld;
   logic             req1_rdy;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             flush0;
   logic             alu_en;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             rsp0_vld;
   logic             rsp0_rdy;
   logic [WIDTH-1:0] rsp0_result;
   logic             rsp1_vld;
   logic             rsp1_rdy;
   logic [WIDTH-1:0] rsp1_result;

   modport slave (
      input  req0_vld, req0_a, req0_b, req0_op, req1_vld, req1_a, req1_b, req1_op,
      input  flush0, alu_result, rsp0_rdy, rsp1_rdy,
      output req0_rdy, req1_rdy, alu_en, alu_a, alu_b, alu_op,
      output rsp0_vld, rsp0_result, rsp1_vld, rsp1_result
   );

   modport master (
      output req0_vld, req0_a, req0_b, req0_op, req1_vld, req1_a, req1_b, req1_op,
      output flush0, alu_result, rsp0_rdy, rsp1_rdy,
      input  req0_rdy, req1_rdy, alu_en, alu_a, alu_b, alu_op,
      input  rsp0_vld, rsp0_result, rsp1_vld, rsp1_result
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between decode (req0, priority) and AGU (req1, starvation-guarded); accept N, ALU N+1, RSP from N+2.
// A requester is held off while its previous result is unconsumed; RSP_READY in the same cycle reopens it.
module alu_share_arbiter #(
   parameter int WIDTH        = 32,
   parameter int OPW          = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   alu_share_arbiter_if.slave  bus
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

   typedef enum logic {PRI0, FORCE1} state_e;

   state_e           state_q;
   logic [CW-1:0]    starve_q, starve_d;
   logic [1:0]       busy_q, busy_d;
   logic [1:0]       rsp_vld_q, rsp_vld_d;
   logic [WIDTH-1:0] rsp0_res_q, rsp1_res_q;
   logic             iss_vld_q, iss_own_q;
   logic [WIDTH-1:0] iss_a_q, iss_b_q;
   logic [OPW-1:0]   iss_op_q;
   logic             hs0, hs1, elig0, elig1, grant0, grant1, cap0, cap1;

   always_comb begin
      hs0    = rsp_vld_q[0] & bus.rsp0_rdy;
      hs1    = rsp_vld_q[1] & bus.rsp1_rdy;
      elig0  = ~busy_q[0] | hs0;
      elig1  = ~busy_q[1] | hs1;
      grant0 = ~rst_i & (state_q == PRI0) & bus.req0_vld & elig0 & ~bus.flush0;
      grant1 = ~rst_i & bus.req1_vld & elig1 & ~grant0;
      // A flushed requester-0 op still occupies the ALU this cycle, but its result is dropped.
      cap0   = iss_vld_q & ~iss_own_q & ~bus.flush0;
      cap1   = iss_vld_q & iss_own_q;

      starve_d = starve_q;
      if (!bus.req1_vld || grant1)
         starve_d = '0;
      else if (elig1 && starve_q != LIM)
         starve_d = starve_q + CW'(1);

      busy_d = busy_q;
      if (hs0 || bus.flush0) busy_d[0] = 1'b0;
      if (hs1)               busy_d[1] = 1'b0;
      if (grant0)            busy_d[0] = 1'b1;
      if (grant1)            busy_d[1] = 1'b1;

      rsp_vld_d = rsp_vld_q;
      if (hs0 || bus.flush0) rsp_vld_d[0] = 1'b0;
      if (hs1)               rsp_vld_d[1] = 1'b0;
      if (cap0)              rsp_vld_d[0] = 1'b1;
      if (cap1)              rsp_vld_d[1] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= PRI0;
         starve_q   <= '0;
         busy_q     <= '0;
         rsp_vld_q  <= '0;
         rsp0_res_q <= '0;
         rsp1_res_q <= '0;
         iss_vld_q  <= 1'b0;
         iss_own_q  <= 1'b0;
         iss_a_q    <= '0;
         iss_b_q    <= '0;
         iss_op_q   <= '0;
      end else begin
         starve_q  <= starve_d;
         busy_q    <= busy_d;
         rsp_vld_q <= rsp_vld_d;
         case (state_q)
            PRI0:    if (starve_d == LIM) state_q <= FORCE1;
            FORCE1:  if (grant1 || !bus.req1_vld) state_q <= PRI0;
            default: state_q <= PRI0;
         endcase
         if (cap0) rsp0_res_q <= bus.alu_result;
         if (cap1) rsp1_res_q <= bus.alu_result;
         iss_vld_q <= grant0 | grant1;
         iss_own_q <= grant1;
         if (grant0) begin
            iss_a_q  <= bus.req0_a;
            iss_b_q  <= bus.req0_b;
            iss_op_q <= bus.req0_op;
         end else if (grant1) begin
            iss_a_q  <= bus.req1_a;
            iss_b_q  <= bus.req1_b;
            iss_op_q <= bus.req1_op;
         end else begin
            iss_a_q  <= '0;
            iss_b_q  <= '0;
            iss_op_q <= '0;
         end
      end
   end

   assign bus.req0_rdy    = grant0;
   assign bus.req1_rdy    = grant1;
   assign bus.alu_en      = iss_vld_q;
   assign bus.alu_a       = iss_a_q;
   assign bus.alu_b       = iss_b_q;
   assign bus.alu_op      = iss_op_q;
   assign bus.rsp0_vld    = rsp_vld_q[0];
   assign bus.rsp1_vld    = rsp_vld_q[1];
   assign bus.rsp0_result = rsp0_res_q;
   assign bus.rsp1_result = rsp1_res_q;
endmodule
